// File: rtl/respondedor_bus.sv
// Bus responder: latches a strobed command, inserts LATENCIA wait states, then
// reads or writes a small RAM or an 8-register port bank and acknowledges once.
module respondedor_bus #(
   parameter int         LATENCIA     = 2,
   parameter int         TAM_RAM      = 32,
   parameter logic [7:0] BASE_PUERTOS = 8'hF8
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        STB,
   input  logic [2:0]  SELEC,
   input  logic [7:0]  DIR_IN,
   input  logic [7:0]  DATO_IN,
   output logic        ACK,
   output logic        ERR,
   output logic [7:0]  DATO_LEIDO,
   output logic        OCUPADO,
   output logic [63:0] PUERTOS,
   output logic [2:0]  estado
);

   localparam int         AW      = (TAM_RAM > 1) ? $clog2(TAM_RAM) : 1;
   localparam logic [3:0] CNT_INI = (LATENCIA > 0) ? 4'(LATENCIA - 1) : 4'd0;
   localparam logic [8:0] LIM_RAM = 9'(TAM_RAM);

   typedef enum logic [2:0] {
      REPOSO = 3'd0,
      ESPERA = 3'd1,
      ACCESO = 3'd2,
      FIN    = 3'd3,
      LIBERA = 3'd4
   } estado_t;

   estado_t    est_q, est_d;
   logic [3:0] cnt_q;
   logic [2:0] sel_q;
   logic [7:0] dir_q;
   logic [7:0] dato_q;
   logic       err_q;
   logic [7:0] leido_q;
   logic [7:0] puertos_q [8];
   logic [7:0] ram [TAM_RAM];

   logic sel_ok, es_lect, es_escr, es_ram, es_puerto;

   always_comb begin
      sel_ok    = (SELEC == 3'b011) || (SELEC == 3'b101) || (SELEC == 3'b110);
      es_lect   = (sel_q == 3'b011);
      es_escr   = (sel_q == 3'b101) || (sel_q == 3'b110);
      es_ram    = ({1'b0, dir_q} < LIM_RAM);
      es_puerto = (dir_q[7:3] == BASE_PUERTOS[7:3]);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) est_q <= REPOSO;
      else        est_q <= est_d;
   end

   always_comb begin
      est_d = est_q;
      case (est_q)
         REPOSO: begin
            if (STB) begin
               if (!sel_ok)           est_d = FIN;
               else if (LATENCIA == 0) est_d = ACCESO;
               else                   est_d = ESPERA;
            end
         end
         ESPERA:  if (cnt_q == 4'd0) est_d = ACCESO;
         ACCESO:  est_d = FIN;
         FIN:     est_d = STB ? LIBERA : REPOSO;
         LIBERA:  if (!STB) est_d = REPOSO;
         default: est_d = REPOSO;
      endcase
   end

   // Command capture, wait counter, error flag, read data and port bank.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt_q   <= 4'd0;
         sel_q   <= 3'd0;
         dir_q   <= 8'd0;
         dato_q  <= 8'd0;
         err_q   <= 1'b0;
         leido_q <= 8'd0;
         for (int i = 0; i < 8; i++) puertos_q[i] <= 8'd0;
      end else begin
         case (est_q)
            REPOSO: begin
               if (STB) begin
                  sel_q  <= SELEC;
                  dir_q  <= DIR_IN;
                  dato_q <= DATO_IN;
                  err_q  <= !sel_ok;
                  cnt_q  <= CNT_INI;
               end
            end
            ESPERA: begin
               if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
            end
            ACCESO: begin
               err_q <= !(es_ram || es_puerto);
               if (es_lect) begin
                  if (es_ram)         leido_q <= ram[dir_q[AW-1:0]];
                  else if (es_puerto) leido_q <= puertos_q[dir_q[2:0]];
               end else if (es_escr && !es_ram && es_puerto) begin
                  puertos_q[dir_q[2:0]] <= dato_q;
               end
            end
            default: ;
         endcase
      end
   end

   // RAM has no reset; a reset before the ACCESO edge leaves the FSM out of ACCESO.
   always_ff @(posedge CLK) begin
      if (est_q == ACCESO && es_escr && es_ram) ram[dir_q[AW-1:0]] <= dato_q;
   end

   assign ACK        = (est_q == FIN);
   assign ERR        = (est_q == FIN) && err_q;
   assign OCUPADO    = (est_q != REPOSO);
   assign DATO_LEIDO = leido_q;
   assign estado     = est_q;

   for (genvar n = 0; n < 8; n++) begin : g_puertos
      assign PUERTOS[8*n +: 8] = puertos_q[n];
   end

endmodule

// File: tb/tb_respondedor_bus.sv
// Bench for respondedor_bus: one instance with LATENCIA=2, one with LATENCIA=0,
// driven by a task; a negedge monitor pops expected {ERR, DATO_LEIDO, cycle} on ACK.
module tb_respondedor_bus;

   logic        clk;
   logic        rst_n;
   logic        stb      [0:1];
   logic [2:0]  selec    [0:1];
   logic [7:0]  dir_in   [0:1];
   logic [7:0]  dato_in  [0:1];
   logic        ack      [0:1];
   logic        err      [0:1];
   logic [7:0]  leido    [0:1];
   logic        ocupado  [0:1];
   logic [63:0] puertos  [0:1];
   logic [2:0]  estado   [0:1];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [8:0] exp_q0[$];
   logic [8:0] exp_q1[$];
   int         cyc_q0[$];
   int         cyc_q1[$];

   respondedor_bus #(.LATENCIA(2), .TAM_RAM(32), .BASE_PUERTOS(8'hF8)) u_dut (
      .CLK(clk), .RST_N(rst_n), .STB(stb[0]), .SELEC(selec[0]), .DIR_IN(dir_in[0]),
      .DATO_IN(dato_in[0]), .ACK(ack[0]), .ERR(err[0]), .DATO_LEIDO(leido[0]),
      .OCUPADO(ocupado[0]), .PUERTOS(puertos[0]), .estado(estado[0])
   );

   respondedor_bus #(.LATENCIA(0), .TAM_RAM(32), .BASE_PUERTOS(8'hF8)) u_dut0 (
      .CLK(clk), .RST_N(rst_n), .STB(stb[1]), .SELEC(selec[1]), .DIR_IN(dir_in[1]),
      .DATO_IN(dato_in[1]), .ACK(ack[1]), .ERR(err[1]), .DATO_LEIDO(leido[1]),
      .OCUPADO(ocupado[1]), .PUERTOS(puertos[1]), .estado(estado[1])
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // monitor / scoreboard
   logic [8:0] m_exp;
   int         m_cyc;
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (rst_n && ack[k]) begin
            if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
               checks++;
               errors++;
               $display("FAIL unexpected_ack dut%0d: got ack=1 expected none at cycle %0d", k, cyc);
            end else begin
               if (k == 0) begin
                  m_exp = exp_q0.pop_front();
                  m_cyc = cyc_q0.pop_front();
               end else begin
                  m_exp = exp_q1.pop_front();
                  m_cyc = cyc_q1.pop_front();
               end
               chk($sformatf("err dut%0d", k), 64'(err[k]), 64'(m_exp[8]));
               chk($sformatf("dato_leido dut%0d", k), 64'(leido[k]), 64'(m_exp[7:0]));
               chk($sformatf("ack_cycle dut%0d", k), 64'(cyc), 64'(m_cyc));
            end
         end
      end
   end

   // driver: called at a negedge, returns at the negedge after ACK
   task automatic issue(input int k, input logic [2:0] sel, input logic [7:0] dir,
                        input logic [7:0] dato, input logic exp_err,
                        input logic [7:0] exp_leido, input bit hold);
      int  lat;
      int  ecyc;
      bit  seen;
      lat  = (k == 0) ? 2 : 0;
      ecyc = cyc + 1;
      if (sel == 3'b011 || sel == 3'b101 || sel == 3'b110) ecyc = ecyc + lat + 1;
      selec[k]   = sel;
      dir_in[k]  = dir;
      dato_in[k] = dato;
      stb[k]     = 1'b1;
      if (k == 0) begin
         exp_q0.push_back({exp_err, exp_leido});
         cyc_q0.push_back(ecyc);
      end else begin
         exp_q1.push_back({exp_err, exp_leido});
         cyc_q1.push_back(ecyc);
      end
      seen = 1'b0;
      for (int n = 0; n < 40 && !seen; n++) begin
         @(negedge clk);
         if (ack[k]) seen = 1'b1;
         else begin
            // inputs after capture must not affect the transaction
            selec[k]   = 3'b011;
            dir_in[k]  = dir ^ 8'h01;
            dato_in[k] = ~dato;
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL ack_timeout dut%0d: got no ack expected one by cycle %0d", k, ecyc);
         if (k == 0) begin
            void'(exp_q0.pop_front());
            void'(cyc_q0.pop_front());
         end else begin
            void'(exp_q1.pop_front());
            void'(cyc_q1.pop_front());
         end
      end
      if (hold) begin
         repeat (10) @(negedge clk);
         chk("estado_libera", 64'(estado[k]), 64'd4);
         chk("ocupado_libera", 64'(ocupado[k]), 64'd1);
      end
      stb[k] = 1'b0;
      @(negedge clk);
      chk("ack_one_cycle", 64'(ack[k]), 64'd0);
      chk("estado_reposo", 64'(estado[k]), 64'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      for (int k = 0; k < 2; k++) begin
         stb[k] = 1'b0; selec[k] = 3'd0; dir_in[k] = 8'd0; dato_in[k] = 8'd0;
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int k = 0; k < 2; k++) begin
         chk("reset_ack", 64'(ack[k]), 64'd0);
         chk("reset_err", 64'(err[k]), 64'd0);
         chk("reset_ocupado", 64'(ocupado[k]), 64'd0);
         chk("reset_dato_leido", 64'(leido[k]), 64'd0);
         chk("reset_puertos", puertos[k], 64'd0);
      end

      issue(0, 3'b110, 8'hFA, 8'h5C, 1'b0, 8'h00, 1'b0);
      chk("port_write_fa", puertos[0], 64'h0000_0000_005C_0000);

      // reset in the middle of the wait states of a port write
      selec[0] = 3'b110; dir_in[0] = 8'hF9; dato_in[0] = 8'h33; stb[0] = 1'b1;
      @(negedge clk);
      chk("espera_ocupado", 64'(ocupado[0]), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_ocupado", 64'(ocupado[0]), 64'd0);
      chk("rst_puertos", puertos[0], 64'd0);
      chk("rst_ack", 64'(ack[0]), 64'd0);
      @(negedge clk);
      stb[0] = 1'b0;
      rst_n  = 1'b1;
      repeat (6) @(negedge clk);
      chk("rst_port1_discarded", 64'(puertos[0][15:8]), 64'd0);

      issue(0, 3'b101, 8'h1F, 8'hA7, 1'b0, 8'h00, 1'b0);
      issue(0, 3'b011, 8'h1F, 8'h00, 1'b0, 8'hA7, 1'b0);
      issue(0, 3'b011, 8'h40, 8'h00, 1'b1, 8'hA7, 1'b0);
      issue(0, 3'b101, 8'h10, 8'h11, 1'b0, 8'hA7, 1'b0);
      issue(0, 3'b000, 8'h10, 8'h55, 1'b1, 8'hA7, 1'b0);
      issue(0, 3'b111, 8'hF8, 8'h77, 1'b1, 8'hA7, 1'b0);
      issue(0, 3'b011, 8'h10, 8'h00, 1'b0, 8'h11, 1'b0);
      issue(0, 3'b110, 8'h80, 8'h99, 1'b1, 8'h11, 1'b0);
      chk("no_port_change", puertos[0], 64'd0);
      issue(0, 3'b110, 8'hFB, 8'h3C, 1'b0, 8'h11, 1'b1);
      chk("hold_port_fb", puertos[0], 64'h0000_0000_3C00_0000);

      issue(1, 3'b110, 8'hF8, 8'h9D, 1'b0, 8'h00, 1'b0);
      issue(1, 3'b011, 8'hF8, 8'h00, 1'b0, 8'h9D, 1'b0);
      issue(1, 3'b101, 8'h00, 8'h42, 1'b0, 8'h9D, 1'b0);
      issue(1, 3'b011, 8'h00, 8'h00, 1'b0, 8'h42, 1'b0);
      chk("lat0_puertos", puertos[1], 64'h0000_0000_0000_009D);

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 64'(exp_q0.size() + exp_q1.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/respondedor_bus.md
# respondedor_bus

Bus responder for the 8-bit micro's external address/data bus. It sits on the far side of the core's output stage, which drives SELEC, DIR_OUT and DATO_OUT. It decodes each strobed bus command, stalls a programmable number of wait states, then performs a write to or read from an internal 32-byte RAM or an 8-register output-port bank. It completes every transaction with a one-cycle ACK and an error flag.

## Interface
- LATENCIA, 2: wait-state cycles inserted before the access (0..15).
- TAM_RAM, 32: RAM depth in bytes, mapped at 0x00..TAM_RAM-1.
- BASE_PUERTOS, 8'hF8: base address of the 8 port registers (0xF8..0xFF); must be ≥ TAM_RAM and 8-aligned.

- CLK  in  1  single clock; all state changes on rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- STB  in  1  request strobe from core; held high with SELEC/DIR_IN/DATO_IN stable until ACK seen.
- SELEC  in  3  command: 3'b011 read, 3'b101 write (register-index form), 3'b110 write (data form); other codes invalid.
- DIR_IN  in  8  address.
- DATO_IN  in  8  write data.
- ACK  out  1  transaction complete, high exactly one cycle.
- ERR  out  1  valid only while ACK=1; 1 = invalid command or unmapped address.
- DATO_LEIDO  out  8  read data; updated only by a successful read, otherwise holds.
- OCUPADO  out  1  high whenever FSM is not in REPOSO.
- PUERTOS  out  64  port registers, port n at bits [8n+7:8n].

## Operation
- States: REPOSO, ESPERA, ACCESO, FIN, LIBERA.
- REPOSO: on STB=1, latch SELEC/DIR_IN/DATO_IN into internal registers.
  - Invalid SELEC: go to FIN with ERR pending.
  - Otherwise go to ESPERA, loading the counter with LATENCIA-1; when LATENCIA=0, go to ACCESO directly.
- ESPERA: decrement counter; at 0 go to ACCESO. Inputs are ignored here; only latched values are used.
- ACCESO (one cycle), address decode on the latched DIR:
  - RAM: DIR < TAM_RAM.
  - PORT: BASE_PUERTOS ≤ DIR ≤ BASE_PUERTOS+7, index = DIR[2:0].
  - Any other address is unmapped.
- Writes (101 and 110 behave identically): DATO is written into RAM or PUERTOS at the edge leaving ACCESO. Unmapped: no state change, ERR pending.
- Reads (011): RAM or port value is loaded into DATO_LEIDO at the edge leaving ACCESO. Unmapped: DATO_LEIDO unchanged, ERR pending.
- ACCESO always goes to FIN.
- FIN: ACK=1, ERR=pending flag. Next state is LIBERA if STB=1, else REPOSO.
- LIBERA: wait for STB=0, then go to REPOSO. No new request is accepted until STB has been low for at least one edge.
- Reset (any time, including mid-transaction):
  - FSM returns to REPOSO; ACK=0, ERR=0, OCUPADO=0, DATO_LEIDO=0x00, PUERTOS=0, counter=0.
  - A write not yet committed at its ACCESO edge is discarded.
  - RAM contents are not reset and are undefined until written.

## Timing
- Capture edge E0: STB sampled high in REPOSO.
- Write and read commit at edge E0+LATENCIA+1.
- ACK high in the cycle after edge E0+LATENCIA+1, for exactly one cycle. Invalid SELEC: ACK in the cycle after E0.
- OCUPADO rises after E0 and falls after the edge that enters REPOSO.
- Minimum spacing: the next capture occurs no earlier than E0+LATENCIA+3.
- PUERTOS and DATO_LEIDO are registered outputs; no combinational path from inputs.
- Changes to SELEC/DIR_IN/DATO_IN after E0 have no effect on the current transaction.

## Test plan
- Reset: RST_N low mid-ESPERA of a write to 0xF9 → PUERTOS=0, ACK never pulses, OCUPADO=0 immediately; port 1 still 0x00 after release.
- Port write: LATENCIA=2, STB with SELEC=110, DIR=0xFA, DATO=0x5C at E0 → PUERTOS[23:16]=0x5C after E0+3; ACK=1 for one cycle after E0+3; ERR=0.
- RAM round trip: write 0xA7 to 0x1F (SELEC=101), drop STB, then read 0x1F (SELEC=011) → DATO_LEIDO=0xA7 with ACK, ERR=0.
- Unmapped and invalid commands:
  - Read 0x40 → ACK with ERR=1, DATO_LEIDO unchanged.
  - SELEC=000 → ACK one cycle after E0 with ERR=1, no memory change.
- Handshake: hold STB high for 10 cycles past ACK → exactly one ACK, FSM in LIBERA. Change DIR during ESPERA → access uses the original address.
- LATENCIA=0: write then read back-to-back → ACK after E0+1 each; capture spacing is 3 cycles.
